// File: rtl/control_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : control_unit_if
// Description : Decode inputs and registered control outputs of the ID-stage
//               control unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface control_unit_if;
    logic [5:0] op_code;
    logic [5:0] control_unit_funct;
    logic       eq_ne;

    logic       reg_write;
    logic       reg_dst;
    logic       ALUSrc_A;
    logic [3:0] ALU_Func;
    logic       mem_write;
    logic       mem_to_reg;
    logic       se_ze;
    logic [1:0] out_select;
    logic       start_mult;
    logic       mult_sign;
    logic       output_branch;
    logic [1:0] pc_source;
    logic       mem_read;
    logic       hilo_sel;

    modport master (
        output op_code, control_unit_funct, eq_ne,
        input  reg_write, reg_dst, ALUSrc_A, ALU_Func, mem_write, mem_to_reg,
               se_ze, out_select, start_mult, mult_sign, output_branch,
               pc_source, mem_read, hilo_sel
    );

    modport slave (
        input  op_code, control_unit_funct, eq_ne,
        output reg_write, reg_dst, ALUSrc_A, ALU_Func, mem_write, mem_to_reg,
               se_ze, out_select, start_mult, mult_sign, output_branch,
               pc_source, mem_read, hilo_sel
    );
endinterface
`default_nettype wire

// File: rtl/control_unit_top.sv
`default_nettype none
// ============================================================================
// Module      : control_unit_top
// Description : ID-stage decode controller for the MIPS-subset pipeline;
//               every control output is registered (one cycle latency).
// Revision    : 1.0 - initial release
// ============================================================================
module control_unit_top (
    input  wire              clk,
    input  wire              rst_n,
    control_unit_if.slave    bus
);
    localparam logic [3:0] c_alu_and  = 4'b0000;
    localparam logic [3:0] c_alu_or   = 4'b0001;
    localparam logic [3:0] c_alu_xor  = 4'b0010;
    localparam logic [3:0] c_alu_xnor = 4'b0011;
    localparam logic [3:0] c_alu_add  = 4'b0100;
    localparam logic [3:0] c_alu_sub  = 4'b1100;
    localparam logic [3:0] c_alu_slt  = 4'b1101;

    // Packed order: reg_write, reg_dst, ALUSrc_A, ALU_Func, mem_write,
    // mem_to_reg, se_ze, out_select, start_mult, mult_sign, output_branch,
    // pc_source, mem_read, hilo_sel
    typedef struct packed {
        logic       reg_write;
        logic       reg_dst;
        logic       alu_src_a;
        logic [3:0] alu_func;
        logic       mem_write;
        logic       mem_to_reg;
        logic       se_ze;
        logic [1:0] out_select;
        logic       start_mult;
        logic       mult_sign;
        logic       output_branch;
        logic [1:0] pc_source;
        logic       mem_read;
        logic       hilo_sel;
    } ctrl_t;

    ctrl_t w_ctrl;
    ctrl_t r_ctrl;

    always_comb begin
        w_ctrl          = '0;
        w_ctrl.mem_read = 1'b1;
        case (bus.op_code)
            6'b000000: begin
                case (bus.control_unit_funct)
                    6'b100000, 6'b100001: begin
                        w_ctrl.reg_write = 1'b1; w_ctrl.reg_dst = 1'b1;
                        w_ctrl.alu_func  = c_alu_add;
                    end
                    6'b100010, 6'b100011: begin
                        w_ctrl.reg_write = 1'b1; w_ctrl.reg_dst = 1'b1;
                        w_ctrl.alu_func  = c_alu_sub;
                    end
                    6'b100100: begin
                        w_ctrl.reg_write = 1'b1; w_ctrl.reg_dst = 1'b1;
                        w_ctrl.alu_func  = c_alu_and;
                    end
                    6'b100101: begin
                        w_ctrl.reg_write = 1'b1; w_ctrl.reg_dst = 1'b1;
                        w_ctrl.alu_func  = c_alu_or;
                    end
                    6'b100110: begin
                        w_ctrl.reg_write = 1'b1; w_ctrl.reg_dst = 1'b1;
                        w_ctrl.alu_func  = c_alu_xor;
                    end
                    6'b001100: begin
                        w_ctrl.reg_write = 1'b1; w_ctrl.reg_dst = 1'b1;
                        w_ctrl.alu_func  = c_alu_xnor;
                    end
                    6'b101010, 6'b101011: begin
                        w_ctrl.reg_write = 1'b1; w_ctrl.reg_dst = 1'b1;
                        w_ctrl.alu_func  = c_alu_slt;
                    end
                    6'b010000, 6'b010010: begin
                        w_ctrl.reg_write  = 1'b1; w_ctrl.reg_dst = 1'b1;
                        w_ctrl.out_select = 2'b11;
                        w_ctrl.hilo_sel   = ~bus.control_unit_funct[1];
                    end
                    6'b011000, 6'b011001: begin
                        w_ctrl.reg_write  = 1'b1; w_ctrl.reg_dst = 1'b1;
                        w_ctrl.out_select = 2'b10;
                        w_ctrl.start_mult = 1'b1;
                        w_ctrl.mult_sign  = ~bus.control_unit_funct[0];
                    end
                    default: ;
                endcase
            end
            6'b000010: begin
                w_ctrl.mem_to_reg = 1'b1;
                w_ctrl.pc_source  = 2'b10;
            end
            6'b000100, 6'b000101: begin
                // BEQ takes on equal, BNE (op_code[0]=1) on not-equal
                w_ctrl.mem_to_reg    = 1'b1;
                w_ctrl.output_branch = bus.eq_ne ^ bus.op_code[0];
                w_ctrl.pc_source     = {1'b0, bus.eq_ne ^ bus.op_code[0]};
            end
            6'b001000, 6'b001001: begin
                w_ctrl.reg_write = 1'b1; w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_func  = c_alu_add; w_ctrl.se_ze = 1'b1;
            end
            6'b001010, 6'b001011: begin
                w_ctrl.reg_write = 1'b1; w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_func  = c_alu_slt; w_ctrl.se_ze = 1'b1;
            end
            6'b001100: begin
                w_ctrl.reg_write = 1'b1; w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_func  = c_alu_and;
            end
            6'b001101: begin
                w_ctrl.reg_write = 1'b1; w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_func  = c_alu_or;
            end
            6'b001110: begin
                w_ctrl.reg_write = 1'b1; w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_func  = c_alu_xor;
            end
            6'b001111: begin
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.out_select = 2'b01;
            end
            6'b100011: begin
                w_ctrl.reg_write = 1'b1; w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_func  = c_alu_add; w_ctrl.se_ze = 1'b1;
            end
            6'b101011: begin
                w_ctrl.mem_write = 1'b1; w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_func  = c_alu_add; w_ctrl.se_ze = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctrl <= '0;
        end else begin
            r_ctrl <= w_ctrl;
        end
    end

    assign bus.reg_write     = r_ctrl.reg_write;
    assign bus.reg_dst       = r_ctrl.reg_dst;
    assign bus.ALUSrc_A      = r_ctrl.alu_src_a;
    assign bus.ALU_Func      = r_ctrl.alu_func;
    assign bus.mem_write     = r_ctrl.mem_write;
    assign bus.mem_to_reg    = r_ctrl.mem_to_reg;
    assign bus.se_ze         = r_ctrl.se_ze;
    assign bus.out_select    = r_ctrl.out_select;
    assign bus.start_mult    = r_ctrl.start_mult;
    assign bus.mult_sign     = r_ctrl.mult_sign;
    assign bus.output_branch = r_ctrl.output_branch;
    assign bus.pc_source     = r_ctrl.pc_source;
    assign bus.mem_read      = r_ctrl.mem_read;
    assign bus.hilo_sel      = r_ctrl.hilo_sel;
endmodule
`default_nettype wire

// File: tb/tb_control_unit_top.sv
`default_nettype none
// ============================================================================
// Module      : tb_control_unit_top
// Description : Scoreboard bench for control_unit_top with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_control_unit_top;
    logic clk;
    logic rst_n;
    control_unit_if bus ();

    control_unit_top dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [18:0] vec;
        string       name;
    } exp_t;

    exp_t        sb_q[$];
    int          total = 0;
    int          bad   = 0;
    logic [18:0] last_exp;
    bit          have_last = 0;

    // {reg_write, reg_dst, ALUSrc_A, ALU_Func, mem_write, mem_to_reg, se_ze,
    //  out_select, start_mult, mult_sign, output_branch, pc_source, mem_read, hilo_sel}
    function automatic logic [18:0] actual();
        return {bus.reg_write, bus.reg_dst, bus.ALUSrc_A, bus.ALU_Func,
                bus.mem_write, bus.mem_to_reg, bus.se_ze, bus.out_select,
                bus.start_mult, bus.mult_sign, bus.output_branch,
                bus.pc_source, bus.mem_read, bus.hilo_sel};
    endfunction

    task automatic check(input string name, input logic [18:0] got, input logic [18:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (rst_n && sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check(e.name, actual(), e.vec);
            last_exp  = e.vec;
            have_last = 1;
        end
    end

    // Drive at negedge; outputs must still show the previous vector until the next edge.
    task automatic issue(input string name, input logic [5:0] op, input logic [5:0] fn,
                         input logic eq, input logic [17:0] v18, input logic hs);
        exp_t e;
        @(negedge clk);
        bus.op_code            = op;
        bus.control_unit_funct = fn;
        bus.eq_ne              = eq;
        e.vec  = {v18, hs};
        e.name = name;
        sb_q.push_back(e);
        #1;
        if (have_last) check({name, "_hold"}, actual(), last_exp);
    endtask

    initial begin
        rst_n                  = 1'b0;
        bus.op_code            = 6'b001000;
        bus.control_unit_funct = 6'b000000;
        bus.eq_ne              = 1'b0;
        repeat (2) @(posedge clk);
        #1 check("reset", actual(), 19'd0);

        @(negedge clk);
        rst_n = 1'b1;
        issue("addi_after_reset", 6'b001000, 6'b000000, 1'b0, 18'b101010000100000001, 1'b0);

        issue("add",    6'b000000, 6'b100000, 1'b0, 18'b110010000000000001, 1'b0);
        issue("addu",   6'b000000, 6'b100001, 1'b1, 18'b110010000000000001, 1'b0);
        issue("sub",    6'b000000, 6'b100010, 1'b0, 18'b110110000000000001, 1'b0);
        issue("xnor",   6'b000000, 6'b001100, 1'b0, 18'b110001100000000001, 1'b0);
        issue("slt",    6'b000000, 6'b101010, 1'b0, 18'b110110100000000001, 1'b0);
        issue("fn_bad", 6'b000000, 6'b111111, 1'b0, 18'b000000000000000001, 1'b0);
        issue("mult",   6'b000000, 6'b011000, 1'b0, 18'b110000000010110001, 1'b0);
        issue("multu",  6'b000000, 6'b011001, 1'b0, 18'b110000000010100001, 1'b0);
        issue("mfhi",   6'b000000, 6'b010000, 1'b0, 18'b110000000011000001, 1'b1);
        issue("mflo",   6'b000000, 6'b010010, 1'b0, 18'b110000000011000001, 1'b0);
        issue("nop",    6'b000000, 6'b000000, 1'b0, 18'b000000000000000001, 1'b0);

        issue("beq_t",  6'b000100, 6'b000000, 1'b1, 18'b000000001000001011, 1'b0);
        issue("beq_nt", 6'b000100, 6'b000000, 1'b0, 18'b000000001000000001, 1'b0);
        issue("bne_t",  6'b000101, 6'b000000, 1'b0, 18'b000000001000001011, 1'b0);
        issue("bne_nt", 6'b000101, 6'b000000, 1'b1, 18'b000000001000000001, 1'b0);
        issue("j",      6'b000010, 6'b000000, 1'b0, 18'b000000001000000101, 1'b0);

        issue("andi",   6'b001100, 6'b000000, 1'b0, 18'b101000000000000001, 1'b0);
        issue("ori",    6'b001101, 6'b000000, 1'b0, 18'b101000100000000001, 1'b0);
        issue("xori",   6'b001110, 6'b000000, 1'b0, 18'b101001000000000001, 1'b0);
        issue("slti",   6'b001010, 6'b000000, 1'b0, 18'b101110100100000001, 1'b0);
        issue("lui",    6'b001111, 6'b000000, 1'b0, 18'b100000000001000001, 1'b0);
        issue("lw",     6'b100011, 6'b000000, 1'b0, 18'b101010000100000001, 1'b0);
        issue("sw",     6'b101011, 6'b000000, 1'b0, 18'b001010010100000001, 1'b0);
        issue("op_bad", 6'b111111, 6'b100000, 1'b0, 18'b000000000000000001, 1'b0);

        // Async reset in the middle of a BEQ-taken cycle
        issue("beq_t2", 6'b000100, 6'b000000, 1'b1, 18'b000000001000001011, 1'b0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check("async_reset", actual(), 19'd0);
        have_last = 0;

        repeat (3) @(posedge clk);
        #1 check("reset_hold", actual(), 19'd0);
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", sb_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/control_unit_top.md
Name: control_unit_top

Overview:
- Main decode controller of the 5-stage MIPS-subset pipeline. Sits in the ID stage.
- Decodes op_code and, for R-type, control_unit_funct. Resolves BEQ/BNE with the register-compare flag eq_ne.
- Drives datapath, memory, multiplier and PC-select controls.
- All outputs are registered, giving one cycle of latency into the next stage.

Parameters:
None.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
op_code  in  6  instruction [31:26]
control_unit_funct  in  6  instruction [5:0], used only when op_code=000000
eq_ne  in  1  1 = compared registers equal
reg_write  out  1  register-file write enable
reg_dst  out  1  1 = rd destination, 0 = rt
ALUSrc_A  out  1  1 = immediate operand, 0 = register
ALU_Func  out  4  ALU op: 0000 AND, 0001 OR, 0010 XOR, 0011 XNOR, 0100 ADD, 1100 SUB, 1101 SLT
mem_write  out  1  data-memory write enable
mem_to_reg  out  1  writeback source select, per table
se_ze  out  1  1 = sign-extend immediate, 0 = zero-extend
out_select  out  2  result mux: 00 ALU, 01 LUI, 10 multiplier, 11 HI/LO
start_mult  out  1  multiplier start
mult_sign  out  1  1 = signed multiply
output_branch  out  1  branch taken
pc_source  out  2  00 PC+4, 01 branch target, 10 jump target
mem_read  out  1  memory read enable
hilo_sel  out  1  1 = HI, 0 = LO (valid when out_select=11)

Behaviour:
- Reset: while rst_n=0, every output is 0, asynchronously.
- Outputs update on each rising clk edge from the op_code, funct and eq_ne sampled at that edge. Latency is 1 cycle.
- There is no other state.
- Default (NOP) vector:
  - mem_read=1.
  - Every other output 0.
- Every decoded row below has mem_read=1 and hilo_sel=0 unless stated.
- Any unlisted field is 0.
- R-type (op_code=000000), rows are by funct:
  - 000000 NOP: default vector.
  - 100000 ADD, 100001 ADDU: reg_write=1, reg_dst=1, ALU=0100.
  - 100010 SUB, 100011 SUBU: reg_write=1, reg_dst=1, ALU=1100.
  - 100100 AND: reg_write=1, reg_dst=1, ALU=0000.
  - 100101 OR: reg_write=1, reg_dst=1, ALU=0001.
  - 100110 XOR: reg_write=1, reg_dst=1, ALU=0010.
  - 001100 XNOR: reg_write=1, reg_dst=1, ALU=0011.
  - 101010 SLT, 101011 SLTU: reg_write=1, reg_dst=1, ALU=1101.
  - 010000 MFHI: reg_write=1, reg_dst=1, out_select=11, hilo_sel=1.
  - 010010 MFLO: reg_write=1, reg_dst=1, out_select=11, hilo_sel=0.
  - 011000 MULT: reg_write=1, reg_dst=1, out_select=10, start_mult=1, mult_sign=1.
  - 011001 MULTU: reg_write=1, reg_dst=1, out_select=10, start_mult=1, mult_sign=0.
  - Any other funct: default vector.
- I/J-type, rows are by op_code:
  - 000010 J: mem_to_reg=1, pc_source=10.
  - 000100 BEQ: mem_to_reg=1. If eq_ne=1, output_branch=1 and pc_source=01. Otherwise output_branch=0 and pc_source=00.
  - 000101 BNE: same as BEQ but taken when eq_ne=0.
  - 001000 ADDI, 001001 ADDIU: reg_write=1, ALUSrc_A=1, ALU=0100, se_ze=1.
  - 001010 SLTI, 001011 SLTIU: reg_write=1, ALUSrc_A=1, ALU=1101, se_ze=1.
  - 001100 ANDI: reg_write=1, ALUSrc_A=1, ALU=0000, se_ze=0.
  - 001101 ORI: reg_write=1, ALUSrc_A=1, ALU=0001, se_ze=0.
  - 001110 XORI: reg_write=1, ALUSrc_A=1, ALU=0010, se_ze=0.
  - 001111 LUI: reg_write=1, out_select=01.
  - 100011 LW: reg_write=1, ALUSrc_A=1, ALU=0100, se_ze=1, mem_to_reg=0.
  - 101011 SW: mem_write=1, ALUSrc_A=1, ALU=0100, se_ze=1.
  - Any other op_code: default vector.
- Branch outcome uses the eq_ne value present at the same edge as the opcode.
- Reset deasserting mid-stream: the first rising edge after release loads the decoded vector.

Test Plan:
- Reset asserted with op_code=001000 -> all outputs 0. Release, one edge -> vector 101010000100000001, ordered {reg_write, reg_dst, ALUSrc_A, ALU_Func, mem_write, mem_to_reg, se_ze, out_select, start_mult, mult_sign, output_branch, pc_source, mem_read}.
- R-type sweep:
  - ADD -> 110010000000000001.
  - SUB -> 110110000000000001.
  - XNOR (funct 001100) -> 110001100000000001.
  - SLT -> 110110100000000001.
  - Unknown funct 111111 -> 000000000000000001.
- MULT -> out_select=10, start_mult=1, mult_sign=1. MULTU -> mult_sign=0. MFHI -> out_select=11, hilo_sel=1. MFLO -> out_select=11, hilo_sel=0.
- Branches, with one-cycle latency checked:
  - BEQ eq_ne=1 -> output_branch=1, pc_source=01.
  - BEQ eq_ne=0 -> output_branch=0, pc_source=00.
  - BNE eq_ne=0 -> taken.
  - BNE eq_ne=1 -> not taken.
  - J -> pc_source=10.
- I-type sweep:
  - ANDI -> 101000000000000001.
  - ORI -> 101000100000000001.
  - XORI -> 101001000000000001.
  - LUI -> out_select=01, reg_write=1.
  - LW -> 101010000100000001.
  - SW -> reg_write=0, mem_write=1, ALU=0100, se_ze=1.
- Assert rst_n asynchronously between clock edges during BEQ-taken -> outputs drop to 0 immediately, without waiting for clk.
